tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Multi-channel tick/timer scheduler. A single shared programmable prescaler feeds NUM_CH independent period counters; each channel emits a one-clock strobe on expiry.
- Channel configuration is sequenced through a valid/ready handshake with one pending slot.
- Updates to a running channel are applied only at its terminal count, so periods change glitch-free.
- Sits between the CPU/register block and consumers needing slow strobes (LED blink, debounce sampling, UART timeouts), replacing per-consumer free-running dividers.

Parameters:
- NUM_CH, 4: number of scheduled channels (1..8).
- CNT_W, 24: width of prescale and period values.
- CH_W, 2: channel index width; must equal clog2(NUM_CH), minimum 1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous active-high reset.
- i_prescale_we  in  1  write strobe for prescale value.
- i_prescale  in  CNT_W  prescaler terminal count; base tick every i_prescale+1 clocks.
- i_cfg_valid  in  1  config request valid.
- o_cfg_ready  out  1  pending slot empty; request accepted when valid&ready.
- i_cfg_ch  in  CH_W  target channel.
- i_cfg_en  in  1  1 = enable/reprogram; 0 = stop channel.
- i_cfg_oneshot  in  1  1 = fire once then self-disable; 0 = periodic.
- i_cfg_period  in  CNT_W  channel terminal count, in base ticks.
- o_tick  out  NUM_CH  per-channel one-clock expiry strobe, registered.
- o_active  out  NUM_CH  per-channel enabled flag.

Behaviour:
- Reset (synchronous, i_reset high at an i_clk edge): prescale=0, pre_cnt=0, all channels disabled with cnt=0/period=0/mode=periodic, pending empty. Outputs after reset: o_tick=0, o_active=0, o_cfg_ready=1. Reset asserted mid-operation aborts any pending config and drops any tick due that cycle.
- Prescaler:
  - pre_tick=1 in the cycle pre_cnt==prescale; pre_cnt then reloads to 0, otherwise increments.
  - prescale=0 gives pre_tick every cycle.
  - i_prescale_we loads prescale and clears pre_cnt; pre_tick is suppressed in the write cycle.
- Channel, enabled, on pre_tick:
  - If cnt==period: o_tick[ch]=1 on the next clock, cnt<=0; if oneshot, en<=0.
  - Otherwise cnt<=cnt+1.
  - Without pre_tick, the channel holds.
  - Tick spacing is (period+1)*(prescale+1) clocks; period=0 fires on every pre_tick.
  - cnt never exceeds period; no wrap logic is needed.
- Config handshake:
  - Accept when i_cfg_valid & o_cfg_ready. Fields latch into the pending slot; o_cfg_ready=0 from the next cycle until the pending entry is applied.
  - Apply rules:
    - target channel disabled and cfg_en=1: apply on the cycle after accept; cnt<=0; channel active from that cycle.
    - target enabled and cfg_en=0: apply on the cycle after accept; cnt<=0; no further ticks (a tick already registered still emits).
    - target enabled and cfg_en=1: hold pending until the channel's terminal event. The old-period tick still fires, then the new period/mode load with cnt=0.
    - target disabled and cfg_en=0: apply immediately; no effect.
  - o_cfg_ready returns to 1 in the cycle after apply.
  - Oneshot self-disable coinciding with a pending update: the pending enable wins and the channel stays active with the new settings.
- o_active[ch] mirrors en; it falls on the clock that emits the final oneshot o_tick.
- i_cfg_ch >= NUM_CH: the request is accepted and dropped, with o_cfg_ready back to 1 the next cycle.

Decomposition:
- Shared package: CNT_W default, channel mode encoding (MODE_PERIODIC=0, MODE_ONESHOT=1), and the pending-slot record (ch, en, oneshot, period).
- One natural sub-module, tick_channel: per-channel counter/period/mode/en plus the terminal compare. It takes pre_tick and load/stop strobes and outputs tick and active. The top holds the prescaler, pending slot and apply logic, with a generate loop over channels.

Test Plan:
- Reset, prescale=0, ch0 period=3 periodic: o_tick[0] every 4 clocks; o_active=0001; o_cfg_ready high again the cycle after apply.
- Prescale=9, ch1 period=4 oneshot: a single o_tick[1] 50 clocks after apply; o_active[1] drops with that tick.
- ch2 running at period=7, reprogram to period=1 mid-count: old tick still at its 8th base tick, then ticks every 2 base ticks; o_cfg_ready low until that terminal event.
- Second config presented while pending: not accepted (ready=0); accepted the cycle after apply, no loss or duplication.
- Prescale write coinciding with pre_tick: no tick in that cycle; new spacing measured from the write; ch0 period=0 then ticks every prescale+1 clocks.
- Reset asserted mid-period with a pending config: all outputs 0, o_cfg_ready=1 next cycle, no stray o_tick afterwards.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// Shared types for the multi-channel tick scheduler.
// Holds the channel mode encoding and the pending-config record.
package tick_scheduler_pkg;

    localparam int CNT_W_DEF = 24;
    localparam int MAX_CNT_W = 32;
    localparam int MAX_CH_W  = 3;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    typedef struct packed {
        logic [MAX_CH_W-1:0]  ch;
        logic                 en;
        mode_e                mode;
        logic [MAX_CNT_W-1:0] period;
    } pend_t;

    function automatic mode_e to_mode(input logic oneshot);
        return oneshot ? MODE_ONESHOT : MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/tick_scheduler_channel.sv
// One scheduled channel: period counter, mode, enable and terminal compare.
// A load on a running channel is only issued by the top at its terminal event.
module tick_channel
    import tick_scheduler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pre_tick,
    input  logic             i_load,
    input  logic             i_stop,
    input  mode_e            i_mode,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_term,
    output logic             o_tick,
    output logic             o_active
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    mode_e            mode_q, mode_d;
    logic             en_q, en_d;
    logic             tick_q, tick_d;

    assign o_term = en_q && i_pre_tick && (cnt_q == period_q);

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        en_d     = en_q;
        tick_d   = 1'b0;
        if (i_stop) begin
            en_d  = 1'b0;
            cnt_d = '0;
        end else if (i_load) begin
            // Old-period tick still fires when the load lands on the terminal count
            en_d     = 1'b1;
            cnt_d    = '0;
            period_d = i_period;
            mode_d   = i_mode;
            tick_d   = o_term;
        end else if (o_term) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            if (mode_q == MODE_ONESHOT) begin
                en_d = 1'b0;
            end
        end else if (en_q && i_pre_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= MODE_PERIODIC;
            en_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
        end
    end

    assign o_tick   = tick_q;
    assign o_active = en_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: shared prescaler, one pending config slot,
// and NUM_CH period counters emitting one-clock expiry strobes.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CH_W   = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_prescale_we,
    input  logic [CNT_W-1:0]  i_prescale,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic              i_cfg_en,
    input  logic              i_cfg_oneshot,
    input  logic [CNT_W-1:0]  i_cfg_period,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_active
);

    logic [CNT_W-1:0]  prescale_q, prescale_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic              pre_tick;
    pend_t             pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic              accept;
    logic              ch_ok;
    logic              apply;
    logic              tgt_active;
    logic              tgt_term;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;
    logic              unused_pend_bits;

    assign pre_tick = !i_prescale_we && (pre_cnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        unique case (1'b1)
            i_prescale_we: begin
                prescale_d = i_prescale;
                pre_cnt_d  = '0;
            end
            pre_tick: pre_cnt_d = '0;
            default:  pre_cnt_d = pre_cnt_q + CNT_W'(1);
        endcase
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = pend_valid_q && (pend_q.ch == MAX_CH_W'(i));
        end
    end

    assign tgt_active = |(sel & active);
    assign tgt_term   = |(sel & term);

    // An enable aimed at a running channel waits for its terminal event
    assign apply = pend_valid_q &&
                   (!pend_q.en || !tgt_active || tgt_term);
    assign load  = sel & {NUM_CH{pend_q.en}} & (~active | term);
    assign stop  = sel & {NUM_CH{!pend_q.en}};

    assign o_cfg_ready = !pend_valid_q;
    assign accept      = i_cfg_valid && o_cfg_ready;
    assign ch_ok       = int'(i_cfg_ch) < NUM_CH;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (apply) begin
            pend_valid_d = 1'b0;
        end
        if (accept && ch_ok) begin
            pend_valid_d  = 1'b1;
            pend_d.ch     = MAX_CH_W'(i_cfg_ch);
            pend_d.en     = i_cfg_en;
            pend_d.mode   = to_mode(i_cfg_oneshot);
            pend_d.period = MAX_CNT_W'(i_cfg_period);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prescale_q   <= '0;
            pre_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            prescale_q   <= prescale_d;
            pre_cnt_q    <= pre_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_pre_tick (pre_tick),
            .i_load     (load[g]),
            .i_stop     (stop[g]),
            .i_mode     (pend_q.mode),
            .i_period   (pend_q.period[CNT_W-1:0]),
            .o_term     (term[g]),
            .o_tick     (tick[g]),
            .o_active   (active[g])
        );
    end

    assign unused_pend_bits = ^pend_q.period;

    assign o_tick   = tick;
    assign o_active = active;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 24;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              prescale_we;
    logic [CNT_W-1:0]  prescale;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic              cfg_en;
    logic              cfg_oneshot;
    logic [CNT_W-1:0]  cfg_period;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_scheduler #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_prescale_we (prescale_we),
        .i_prescale    (prescale),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_ch      (cfg_ch),
        .i_cfg_en      (cfg_en),
        .i_cfg_oneshot (cfg_oneshot),
        .i_cfg_period  (cfg_period),
        .o_tick        (tick),
        .o_active      (active)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic v, input logic [CH_W-1:0] ch,
                       input logic en, input logic os,
                       input logic [CNT_W-1:0] per);
        cfg_valid   = v;
        cfg_ch      = ch;
        cfg_en      = en;
        cfg_oneshot = os;
        cfg_period  = per;
    endtask

    initial begin
        logic [3:0] exp;
        reset       = 1'b1;
        prescale_we = 1'b0;
        prescale    = '0;
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        step();
        step();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        reset = 1'b0;

        // ch0 periodic, period 3, prescale 0
        cfg(1'b1, 2'd0, 1'b1, 1'b0, 24'd3);
        step();
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        chk("s1_ready_lo", 32'(cfg_ready), 0);
        chk("s1_active_pre", 32'(active), 0);
        step();
        chk("s1_ready_hi", 32'(cfg_ready), 1);
        chk("s1_active", 32'(active), 4'b0001);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("s1_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
        end
        cfg(1'b1, 2'd0, 1'b0, 1'b0, 24'd0);
        step();
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        chk("s1_stop_ready_lo", 32'(cfg_ready), 0);
        step();
        chk("s1_stop_active", 32'(active), 0);
        chk("s1_stop_ready_hi", 32'(cfg_ready), 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("s1_stop_tick", 32'(tick), 0);
        end

        // prescale 9, ch1 oneshot period 4, applied on a pre_tick edge
        prescale_we = 1'b1;
        prescale    = 24'd9;
        step();
        prescale_we = 1'b0;
        repeat (8) step();
        cfg(1'b1, 2'd1, 1'b1, 1'b1, 24'd4);
        step();
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        chk("s2_ready_lo", 32'(cfg_ready), 0);
        step();
        chk("s2_ready_hi", 32'(cfg_ready), 1);
        chk("s2_active", 32'(active), 4'b0010);
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("s2_tick", 32'(tick), (k == 50) ? 4'b0010 : 4'b0000);
            chk("s2_active_k", 32'(active), (k == 50) ? 4'b0000 : 4'b0010);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("s2_after_tick", 32'(tick), 0);
        end

        // ch2 period 7 reprogrammed to 1; ch3 config queued behind it
        prescale_we = 1'b1;
        prescale    = 24'd0;
        cfg(1'b1, 2'd2, 1'b1, 1'b0, 24'd7);
        step();
        prescale_we = 1'b0;
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        step();
        chk("s3_active", 32'(active), 4'b0100);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp    = '0;
            exp[2] = (k == 8) || (k > 8 && k % 2 == 0);
            exp[3] = (k > 10) && ((k - 10) % 3 == 0);
            chk("s3_tick", 32'(tick), 32'(exp));
            chk("s3_ready", 32'(cfg_ready),
                ((k >= 4 && k <= 7) || k == 9) ? 0 : 1);
            if (k == 3) cfg(1'b1, 2'd2, 1'b1, 1'b0, 24'd1);
            if (k == 4) cfg(1'b1, 2'd3, 1'b1, 1'b0, 24'd2);
            if (k == 9) cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        end
        chk("s3_active_end", 32'(active), 4'b1100);

        // reset with a pending config and a tick due in the reset cycle
        cfg(1'b1, 2'd2, 1'b1, 1'b0, 24'd5);
        step();
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        chk("s6_ready_lo", 32'(cfg_ready), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s6_tick", 32'(tick), 0);
        chk("s6_active", 32'(active), 0);
        chk("s6_ready", 32'(cfg_ready), 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("s6_quiet_tick", 32'(tick), 0);
            chk("s6_quiet_active", 32'(active), 0);
        end

        // prescale 3, ch0 period 0; rewrite to 5 on a pre_tick edge
        prescale_we = 1'b1;
        prescale    = 24'd3;
        cfg(1'b1, 2'd0, 1'b1, 1'b0, 24'd0);
        step();
        prescale_we = 1'b0;
        cfg(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("s5_tick", 32'(tick),
                (k == 4 || k == 14 || k == 20) ? 1 : 0);
            if (k == 7) begin
                prescale_we = 1'b1;
                prescale    = 24'd5;
            end
            if (k == 8) prescale_we = 1'b0;
        end
        chk("s5_active", 32'(active), 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
